// File: rtl/adc_pkg.sv
// Shared types, tdata field layout and beat packing for the ADC frame packer.
package adc_pkg;

  localparam int unsigned TDATA_W      = 32;
  localparam int unsigned CH_IDX_LSB   = 24;
  localparam int unsigned CH_IDX_W     = 8;
  localparam int unsigned SEQ_LSB      = 16;
  localparam int unsigned SEQ_W        = 8;
  localparam int unsigned SAMPLE_W_MAX = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Assemble one AXIS beat: {ch_idx, seq, zero-extended sample}.
  function automatic logic [TDATA_W-1:0] pack_beat(
    input logic [CH_IDX_W-1:0]     ch,
    input logic [SEQ_W-1:0]        seq,
    input logic [SAMPLE_W_MAX-1:0] smp
  );
    logic [TDATA_W-1:0] b;
    b = '0;
    b[CH_IDX_LSB +: CH_IDX_W] = ch;
    b[SEQ_LSB +: SEQ_W]       = seq;
    b[0 +: SAMPLE_W_MAX]      = smp;
    return b;
  endfunction

endpackage

// File: rtl/adc_ch_scan.sv
// Lowest-set-bit priority encoder over the remaining channel mask.
module adc_ch_scan
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH = 16
) (
  input  logic [NUM_CH-1:0]   i_bits,
  output logic [CH_IDX_W-1:0] o_idx,
  output logic                o_valid,
  output logic                o_last,
  output logic [NUM_CH-1:0]   o_rest
);

  // Mask with the lowest set bit removed; empty means the picked bit is the final one.
  assign o_rest  = i_bits & (i_bits - NUM_CH'(1));
  assign o_valid = |i_bits;
  assign o_last  = o_valid & ~(|o_rest);

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_bits[i]) o_idx = CH_IDX_W'(i);
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Snapshots ADC channel samples on a decimated strobe and streams enabled channels as tagged AXIS beats.
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned SAMPLE_W   = 12,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                         CLK100MHz,
  input  logic                         ARESETN,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [15:0]                  decim,
  input  logic [15:0]                  frames_per_packet,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  input  logic                         sample_valid,
  output logic [TDATA_W-1:0]           m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [3:0]                   m_axis_tkeep,
  output logic                         overflow,
  input  logic                         clear_overflow,
  output logic [DROP_CNT_W-1:0]        drop_count,
  output logic                         busy
);

  localparam int unsigned FRAME_W = NUM_CH * SAMPLE_W;
  localparam int unsigned CNT_W   = 16;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_dec_cnt, r_decim_l;
  logic                  r_pend_full;
  logic [NUM_CH-1:0]     r_pend_mask;
  logic [FRAME_W-1:0]    r_pend_data, r_act_data;
  logic [NUM_CH-1:0]     r_rem;
  logic [SEQ_W-1:0]      r_seq, r_act_seq;
  logic [CNT_W-1:0]      r_fip, r_fpp_l;
  logic                  r_tvalid, r_tlast;
  logic [TDATA_W-1:0]    r_tdata;
  logic                  r_overflow, r_busy;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_stb, w_acc, w_hs, w_drop, w_fill;
  logic                  w_start, w_advance, w_load, w_pend_ok, w_close;
  logic                  w_pend_full_nxt, w_busy_nxt;
  logic [CNT_W-1:0]      w_dec_lim, w_fpp_cur, w_fpp_use;
  logic [NUM_CH-1:0]     w_scan_in, w_scan_rest;
  logic [CH_IDX_W-1:0]   w_scan_idx;
  logic                  w_scan_valid, w_scan_last;
  logic [FRAME_W-1:0]    w_src;
  logic [SEQ_W-1:0]      w_beat_seq;
  logic [SAMPLE_W-1:0]   w_sample;

  // Strobe qualification and decimation; decim is sampled on the first strobe of each period.
  assign w_stb     = sample_valid & enable & (|ch_mask);
  assign w_dec_lim = (r_dec_cnt == '0) ? decim : r_decim_l;
  assign w_acc     = w_stb & (r_dec_cnt == w_dec_lim);
  assign w_hs      = r_tvalid & m_axis_tready;

  // Scan the active frame's remaining bits, or PEND's mask once the active frame is exhausted.
  assign w_scan_in = (r_rem != '0) ? r_rem : r_pend_mask;

  adc_ch_scan #(.NUM_CH(NUM_CH)) u_scan (
    .i_bits  (w_scan_in),
    .o_idx   (w_scan_idx),
    .o_valid (w_scan_valid),
    .o_last  (w_scan_last),
    .o_rest  (w_scan_rest)
  );

  // A PEND frame may start only while enabled; it is discarded otherwise.
  assign w_pend_ok = enable & r_pend_full & w_scan_valid;

  // Next-state and beat-load control.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend_ok) begin
          w_start     = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (r_rem != '0)    w_advance   = 1'b1;
          else if (w_pend_ok) w_start     = 1'b1;
          else                w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load     = w_start | w_advance;
  assign w_src      = w_start ? r_pend_data : r_act_data;
  assign w_beat_seq = w_start ? r_seq : r_act_seq;

  // Select the sample for the channel being loaded.
  always_comb begin
    w_sample = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_scan_idx == CH_IDX_W'(i)) w_sample = w_src[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Packet close: final beat of the frame that completes the count, or any final beat once disabled.
  assign w_fpp_cur = (frames_per_packet == '0) ? CNT_W'(1) : frames_per_packet;
  assign w_fpp_use = (w_start && (r_fip == '0)) ? w_fpp_cur : r_fpp_l;
  assign w_close   = w_scan_last & (((r_fip + CNT_W'(1)) == w_fpp_use) | ~enable);

  // PEND occupancy; a frame leaving PEND in the same cycle makes room for the new one.
  assign w_drop          = w_acc & r_pend_full & ~w_start;
  assign w_fill          = w_acc & ~w_drop;
  assign w_pend_full_nxt = enable & (w_fill | (r_pend_full & ~w_start));
  assign w_busy_nxt      = w_pend_full_nxt | (w_state_nxt == SEND);

  // State register.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Decimation counter.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      r_dec_cnt <= '0;
      r_decim_l <= '0;
    end else if (!enable) begin
      r_dec_cnt <= '0;
    end else if (w_stb) begin
      if (r_dec_cnt == '0) r_decim_l <= decim;
      r_dec_cnt <= w_acc ? '0 : r_dec_cnt + CNT_W'(1);
    end
  end

  // PEND frame register.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pend_full <= 1'b0;
      r_pend_mask <= '0;
      r_pend_data <= '0;
    end else begin
      r_pend_full <= w_pend_full_nxt;
      if (w_fill) begin
        r_pend_mask <= ch_mask;
        r_pend_data <= sample_data;
      end
    end
  end

  // ACTIVE frame, tagging counters and the registered AXIS beat.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      r_act_data <= '0;
      r_act_seq  <= '0;
      r_seq      <= '0;
      r_fpp_l    <= CNT_W'(1);
      r_fip      <= '0;
      r_rem      <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
    end else begin
      if (w_start) begin
        r_act_data <= r_pend_data;
        r_act_seq  <= r_seq;
        r_seq      <= r_seq + SEQ_W'(1);
        if (r_fip == '0) r_fpp_l <= w_fpp_cur;
      end
      if (w_load) begin
        r_rem    <= w_scan_rest;
        r_tvalid <= 1'b1;
        r_tlast  <= w_close;
        r_tdata  <= pack_beat(w_scan_idx, w_beat_seq, SAMPLE_W_MAX'(w_sample));
        if (w_scan_last) r_fip <= w_close ? '0 : r_fip + CNT_W'(1);
      end else begin
        if (w_hs) begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
        if (!enable && (r_state == IDLE)) r_fip <= '0;
      end
    end
  end

  // Sticky overflow, saturating drop counter and busy flag; a drop beats a same-cycle clear.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clear_overflow)       r_drop_cnt <= DROP_CNT_W'(1);
        else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tkeep  = 4'hF;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_cnt;
  assign busy          = r_busy;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: table of framing scenarios plus hand sequences.
module tb_adc_frame_packer;

  localparam int NUM_CH     = 16;
  localparam int SAMPLE_W   = 12;
  localparam int DROP_CNT_W = 16;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       enable = 1'b0;
  logic [NUM_CH-1:0]          ch_mask = '0;
  logic [15:0]                decim = '0;
  logic [15:0]                fpp = '0;
  logic [NUM_CH*SAMPLE_W-1:0] sample_data = '0;
  logic                       sample_valid = 1'b0;
  logic [31:0]                tdata;
  logic                       tvalid;
  logic                       tready = 1'b1;
  logic                       tlast;
  logic [3:0]                 tkeep;
  logic                       overflow;
  logic                       clear_overflow = 1'b0;
  logic [DROP_CNT_W-1:0]      drop_count;
  logic                       busy;

  always #5 clk = ~clk;

  adc_frame_packer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DROP_CNT_W(DROP_CNT_W)) dut (
    .CLK100MHz         (clk),
    .ARESETN           (rst_n),
    .enable            (enable),
    .ch_mask           (ch_mask),
    .decim             (decim),
    .frames_per_packet (fpp),
    .sample_data       (sample_data),
    .sample_valid      (sample_valid),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tready     (tready),
    .m_axis_tlast      (tlast),
    .m_axis_tkeep      (tkeep),
    .overflow          (overflow),
    .clear_overflow    (clear_overflow),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int first_cyc = -1;
  int strb_cyc  = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every handshaked beat; sampled mid-cycle where all signals are settled.
  always @(negedge clk) begin
    if (tvalid && first_cyc < 0) first_cyc = cyc;
    if (tvalid && tready) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
    end
  end

  typedef struct {
    logic [15:0] mask;
    logic [15:0] decim;
    logic [15:0] fpp;
    int          n_strb;
    int          exp_lat;
    int          exp_beats;
    int          exp_tlast;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qd(input int i);
    if (i >= 0 && i < q_data.size()) return q_data[i];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] ql(input int i);
    if (i >= 0 && i < q_last.size()) return {31'b0, q_last[i]};
    return 32'hDEADBEEF;
  endfunction

  function automatic int n_tlast();
    int n = 0;
    foreach (q_last[i]) if (q_last[i]) n++;
    return n;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    first_cyc = -1;
  endtask

  task automatic do_reset();
    sample_valid   = 1'b0;
    clear_overflow = 1'b0;
    enable         = 1'b0;
    tready         = 1'b1;
    rst_n          = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
  endtask

  // One strobe; channel i carries base+i.
  task automatic strobe(input int base);
    for (int i = 0; i < NUM_CH; i++) sample_data[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(base + i);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Bounded wait for the packer to drain.
  task automatic wait_idle(input string name);
    int n = 0;
    repeat (3) tick();
    while ((busy || tvalid) && n < 500) begin
      tick();
      n++;
    end
    check({name, "_idle"}, {30'b0, busy, tvalid}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //           mask      decim  fpp    strb lat beats tlast first          last
    vecs[0] = '{16'hFFFF, 16'd0, 16'd1,  1,   2,  16,   1,    32'h00000100,  32'h0F00010F};
    vecs[1] = '{16'h8005, 16'd0, 16'd2,  2,   2,  6,    1,    32'h00000100,  32'h0F01020F};
    vecs[2] = '{16'h0001, 16'd3, 16'd1,  12,  -1, 3,    3,    32'h00000400,  32'h00020C00};
    vecs[3] = '{16'h0010, 16'd1, 16'd3,  6,   -1, 3,    1,    32'h04000204,  32'h04020604};
    vecs[4] = '{16'h0C00, 16'd0, 16'd0,  2,   2,  4,    2,    32'h0A00010A,  32'h0B01020B};

    do_reset();
    check("rst_tvalid", {31'b0, tvalid}, 32'h0);
    check("rst_tlast", {31'b0, tlast}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("tkeep", {28'b0, tkeep}, 32'hF);

    // Table-driven framing scenarios.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      ch_mask = vecs[v].mask;
      decim   = vecs[v].decim;
      fpp     = vecs[v].fpp;
      enable  = 1'b1;
      tick();
      for (int k = 1; k <= vecs[v].n_strb; k++) begin
        if (k == 1) strb_cyc = cyc;
        strobe(k * 256);
        wait_idle($sformatf("v%0d_s%0d", v, k));
      end
      if (vecs[v].exp_lat >= 0)
        check($sformatf("v%0d_latency", v), 32'(first_cyc - strb_cyc), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_beats", v), 32'(q_data.size()), 32'(vecs[v].exp_beats));
      check($sformatf("v%0d_tlast_cnt", v), 32'(n_tlast()), 32'(vecs[v].exp_tlast));
      check($sformatf("v%0d_first", v), qd(0), vecs[v].exp_first);
      check($sformatf("v%0d_last", v), qd(q_data.size() - 1), vecs[v].exp_last);
      check($sformatf("v%0d_last_tlast", v), ql(q_last.size() - 1), 32'h1);
    end

    // Full-mask frame tagging, beat by beat.
    do_reset();
    ch_mask = 16'hFFFF; decim = 16'd0; fpp = 16'd1; enable = 1'b1;
    tick();
    strobe(256);
    wait_idle("full");
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_d;
      exp_d = 32'h00000100 + 32'(i);
      exp_d[31:24] = 8'(i);
      check($sformatf("full_beat%0d", i), qd(i), exp_d);
    end

    // Backpressure: two frames buffer, the third drops; clear and drop-vs-clear priority.
    do_reset();
    ch_mask = 16'h0003; decim = 16'd0; fpp = 16'd1; tready = 1'b0; enable = 1'b1;
    tick();
    strobe(256);
    tick();
    strobe(512);
    tick();
    strobe(768);
    check("bp_overflow", {31'b0, overflow}, 32'h1);
    check("bp_drop_count", 32'(drop_count), 32'h1);
    check("bp_busy", {31'b0, busy}, 32'h1);
    check("bp_tdata_held", tdata, 32'h00000100);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("bp_clr_overflow", {31'b0, overflow}, 32'h0);
    check("bp_clr_drop_count", 32'(drop_count), 32'h0);
    clear_overflow = 1'b1;
    strobe(1024);
    clear_overflow = 1'b0;
    check("bp_drop_wins_ovf", {31'b0, overflow}, 32'h1);
    check("bp_drop_wins_cnt", 32'(drop_count), 32'h1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    tready = 1'b1;
    wait_idle("bp");
    check("bp_beats", 32'(q_data.size()), 32'd4);
    check("bp_beat0", qd(0), 32'h00000100);
    check("bp_beat2", qd(2), 32'h00010200);
    check("bp_beat3", qd(3), 32'h01010201);
    check("bp_tlast_cnt", 32'(n_tlast()), 32'd2);

    // Enable falls mid-frame: short packet closes, PEND is discarded.
    do_reset();
    ch_mask = 16'h00FF; decim = 16'd0; fpp = 16'd4; enable = 1'b1;
    tick();
    strobe(256);
    wait_idle("en_f1");
    strobe(512);
    strobe(768);
    tick();
    enable = 1'b0;
    strobe(1024);
    wait_idle("en_f2");
    repeat (20) tick();
    check("en_beats", 32'(q_data.size()), 32'd16);
    check("en_tlast_cnt", 32'(n_tlast()), 32'd1);
    check("en_f1_tlast", ql(7), 32'h0);
    check("en_f2_tlast", ql(15), 32'h1);
    check("en_f2_last", qd(15), 32'h07010207);
    check("en_busy", {31'b0, busy}, 32'h0);
    check("en_overflow", {31'b0, overflow}, 32'h0);

    // Asynchronous reset mid-beat, then a fresh packet with seq restarting at 0.
    do_reset();
    ch_mask = 16'hFFFF; decim = 16'd0; fpp = 16'd2; enable = 1'b1;
    tick();
    strobe(256);
    wait_idle("rs_f1");
    strobe(512);
    tick();
    tick();
    check("rs_pre_tvalid", {31'b0, tvalid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_tvalid", {31'b0, tvalid}, 32'h0);
    check("rs_busy", {31'b0, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
    strobe(768);
    wait_idle("rs_f2");
    strobe(1024);
    wait_idle("rs_f3");
    check("rs_beats", 32'(q_data.size()), 32'd32);
    check("rs_first", qd(0), 32'h00000300);
    check("rs_second_frame", qd(16), 32'h00010400);
    check("rs_mid_tlast", ql(15), 32'h0);
    check("rs_tlast_cnt", 32'(n_tlast()), 32'd1);
    check("rs_end_tlast", ql(31), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
Parametrised successor to the fixed 16-channel ADC-to-AXIS glue. Snapshots all ADC channel results on a conversion strobe and decimates the strobe rate. Serialises only the enabled channels into a tagged 32-bit AXI4-Stream, one beat per channel, with packet framing. Sits between the adc_7276 instance array (eoc/sample strobe, sample vector) and the DMA-facing AXIS port; configuration comes from the AXI-Lite register block.

Parameters:
NUM_CH, 16, number of ADC channels in sample_data (1..64)
SAMPLE_W, 12, bits per channel sample (1..16)
DROP_CNT_W, 16, width of the dropped-frame counter

Ports:
CLK100MHz  in  1  single system clock; all logic rising-edge
ARESETN  in  1  reset, asynchronous assert, active-low
enable  in  1  packer enable (level)
ch_mask  in  NUM_CH  per-channel enable; bit i enables channel i
decim  in  16  accept one strobe in every decim+1
frames_per_packet  in  16  frames per AXIS packet; 0 treated as 1
sample_data  in  NUM_CH*SAMPLE_W  channel i at [i*SAMPLE_W +: SAMPLE_W]
sample_valid  in  1  1-cycle strobe, sample_data valid this cycle
m_axis_tdata  out  32  {ch_idx[7:0], seq[7:0], zero-extended sample[15:0]}
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tlast  out  1  last beat of packet
m_axis_tkeep  out  4  constant 4'hF
overflow  out  1  sticky: a frame was dropped
clear_overflow  in  1  1-cycle pulse; clears overflow and drop_count
drop_count  out  DROP_CNT_W  dropped frames, saturating
busy  out  1  any frame buffered or being sent

Behaviour:
- Reset: ARESETN low clears all state asynchronously, mid-packet included. tvalid, tlast, overflow, busy and drop_count go to 0. Decimation counter, seq and the frame-in-packet counter go to 0. State goes to IDLE. Buffered frames are discarded; no partial packet is resumed.
- Strobe qualification: a strobe counts only when enable=1 and ch_mask!=0. It increments the decimation counter. A strobe is accepted when the counter equals decim, and the counter then returns to 0. decim=0 accepts every strobe.
- Buffering: two frame registers, PEND and ACTIVE. Each holds all samples plus a ch_mask latched at accept time.
  - An accepted strobe is written to PEND in the next cycle.
  - If PEND is full, the frame is dropped: overflow is set, drop_count increments and saturates at all-ones.
  - Exception: if ACTIVE's final beat handshakes in the same cycle, PEND moves to ACTIVE and the new frame fills PEND. No drop.
- FSM:
  - IDLE -> SEND when PEND is full. PEND moves to ACTIVE. tvalid rises the cycle after.
  - SEND emits one beat per set bit of the latched mask, ascending channel index. A priority encoder picks the lowest remaining bit.
  - After the last beat handshakes, SEND -> SEND if PEND is full (back-to-back, no bubble), otherwise IDLE.
- Latency: strobe at cycle N with the packer idle gives first beat tvalid at N+2.
- AXIS rules:
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - No combinational path from tready to tvalid.
  - Throughput is one beat per cycle while tready=1.
- Tagging: ch_idx is the channel number. seq is a per-frame counter that increments after each frame's last beat and wraps 255->0.
- Packets: frames_per_packet is latched at packet start. tlast is asserted on the last beat of the frame that completes the count, and the count then resets.
- enable falling:
  - No new strobes are accepted.
  - The frame in ACTIVE completes, and its last beat carries tlast, closing a short packet.
  - PEND is discarded and the decimation counter is cleared.
- Configuration timing: ch_mask changes affect only frames accepted afterwards. decim changes take effect at the next counter wrap.
- clear_overflow in the same cycle as a drop: the drop wins, leaving overflow=1 and drop_count=1.

Decomposition:
- Shared package adc_pkg holds:
  - the state enum (IDLE, SEND);
  - the tdata field offsets/widths (CH_IDX_LSB=24, SEQ_LSB=16, SAMPLE_W_MAX=16);
  - the function packing a beat.
- Sub-module adc_ch_scan: combinational lowest-set-bit priority encoder over NUM_CH bits. Outputs the index, a valid flag, and a last flag (exactly one bit remaining).

Test Plan:
1. NUM_CH=16, mask=16'hFFFF, decim=0, fpp=1, tready=1, strobe carrying sample i = 0x100+i -> 16 beats. tdata = 0x00000100 through 0x0F00010F. tlast on beat 16; first tvalid 2 cycles after the strobe.
2. mask=16'h8005, fpp=2, two strobes -> beats for ch 0, 2, 15 with seq 0, then ch 0, 2, 15 with seq 1. tlast only on the 6th beat.
3. decim=3, 12 strobes -> exactly 3 frames emitted, from strobes 4, 8 and 12.
4. tready=0, three strobes -> frames 1 and 2 buffered. Third strobe dropped: overflow=1, drop_count=1. clear_overflow pulse -> both 0. Release tready -> frames with seq 0 and 1 only.
5. fpp=4, enable dropped during the 2nd frame -> 2nd frame completes with tlast=1. No further beats; busy falls to 0.
6. ARESETN asserted mid-beat with tvalid=1 -> tvalid=0 immediately. After release, the next frame has seq=0 and starts a new packet.
